// File: rtl/inst_fetch_queue_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch queue
// Provides fetch_entry_t {pc, inst}, FETCH_DEPTH_DEFAULT, INST_NOP and align_pc().
package fetch_pkg;
  localparam int FETCH_DEPTH_DEFAULT = 4;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: ROM, redirect and decode handshake bundle of the fetch stage
// master (fetch): drives rom_addr, inst_valid, inst_data, inst_pc, count;
// samples rom_data, redirect_valid, redirect_pc, inst_ready. slave is the mirror.
interface inst_fetch_queue_if import fetch_pkg::*; #(parameter int DEPTH = FETCH_DEPTH_DEFAULT);
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic inst_valid;
  logic inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output rom_addr, inst_valid, inst_data, inst_pc, count,
    input rom_data, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input rom_addr, inst_valid, inst_data, inst_pc, count,
    output rom_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// fetch_fifo: power-of-two FIFO of fetch_entry_t with synchronous flush
// Ports: clk, reset (async active-low), i_flush/i_push/i_pop, i_data in;
// o_head (entry at read pointer), o_full, o_empty, o_count out.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  fetch_entry_t           i_data,
  output fetch_entry_t           o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0] r_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr <= r_wptr + 1'b1;
      end
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  assign o_head = r_mem[r_rptr];
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: PC-driven ROM fetch into a prefetch queue feeding decode, with redirect flush
// Ports: clk, reset (async active-low), bus (inst_fetch_queue_if.master).
// Optional macro FETCH_BYPASS_EN: an empty queue forwards rom_data/fetch_pc straight to decode.
module inst_fetch_queue import fetch_pkg::*; #(
  parameter int          DEPTH    = FETCH_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                reset,
  inst_fetch_queue_if.master bus
);
  logic [31:0] r_fetch_pc;
  fetch_entry_t w_head;
  logic w_full;
  logic w_empty;
  logic w_byp;
  logic w_pop;
  logic w_push;
  logic w_adv;
  logic [$clog2(DEPTH):0] w_count;
`ifdef FETCH_BYPASS_EN
  assign w_byp = w_empty && !bus.redirect_valid;
`else
  assign w_byp = 1'b0;
`endif
  assign bus.inst_valid = !w_empty || w_byp;
  assign bus.inst_data = w_byp ? bus.rom_data : w_head.inst;
  assign bus.inst_pc = w_byp ? r_fetch_pc : w_head.pc;
  assign w_pop = bus.inst_valid && bus.inst_ready;
  // a bypassed word consumed by decode advances the PC without occupying a slot
  assign w_push = !bus.redirect_valid && (!w_full || w_pop) && !(w_byp && bus.inst_ready);
  assign w_adv = w_push || (w_byp && bus.inst_ready);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fetch_pc <= RESET_PC;
    else if (bus.redirect_valid) r_fetch_pc <= align_pc(bus.redirect_pc);
    else if (w_adv) r_fetch_pc <= r_fetch_pc + 32'd4;
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop && !w_empty),
    .i_data  ({r_fetch_pc, bus.rom_data}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  assign bus.rom_addr = r_fetch_pc;
  assign bus.count = w_count;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for inst_fetch_queue (default build)
module tb_inst_fetch_queue;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  inst_fetch_queue_if #(.DEPTH(4)) bus ();
  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a == 32'h0 ? 32'h0011_0233 : INST_NOP ^ {a[23:0], 8'h00};
  endfunction
  assign bus.rom_data = rom_word(bus.rom_addr);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    step();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
  endtask
  initial begin
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    #1 reset = 1'b0;
    #2;
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_addr", bus.rom_addr, 32'h0);
    check("rst_data", bus.inst_data, 32'h0);
    check("rst_pc", bus.inst_pc, 32'h0);
    step();
    reset = 1'b1;
    step();
    check("first_valid", 32'(bus.inst_valid), 32'd1);
    check("first_pc", bus.inst_pc, 32'h0);
    repeat (5) step();
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_addr", bus.rom_addr, 32'h10);
    check("fill_pc", bus.inst_pc, 32'h0);
    check("fill_data", bus.inst_data, 32'h0011_0233);
    step();
    check("full_hold_addr", bus.rom_addr, 32'h10);
    bus.inst_ready = 1'b1;
    step();
    check("fullpp_count1", 32'(bus.count), 32'd4);
    check("fullpp_addr1", bus.rom_addr, 32'h14);
    check("fullpp_pc1", bus.inst_pc, 32'h4);
    step();
    check("fullpp_count2", 32'(bus.count), 32'd4);
    check("fullpp_addr2", bus.rom_addr, 32'h18);
    check("fullpp_pc2", bus.inst_pc, 32'h8);
    check("fullpp_data2", bus.inst_data, rom_word(32'h8));
    bus.inst_ready = 1'b0;
    redirect(32'h50);
    check("redir_count", 32'(bus.count), 32'd0);
    check("redir_valid", 32'(bus.inst_valid), 32'd0);
    check("redir_addr", bus.rom_addr, 32'h50);
    step();
    check("redir_head_pc", bus.inst_pc, 32'h50);
    check("redir_head_data", bus.inst_data, rom_word(32'h50));
    check("redir_head_valid", 32'(bus.inst_valid), 32'd1);
    check("redir_next_addr", bus.rom_addr, 32'h54);
    redirect(32'h52);
    check("misalign_addr", bus.rom_addr, 32'h50);
    step();
    check("misalign_pc", bus.inst_pc, 32'h50);
    redirect(32'hFFFF_FFFE);
    check("wrap_addr0", bus.rom_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", bus.rom_addr, 32'h0);
    check("wrap_pc", bus.inst_pc, 32'hFFFF_FFFC);
    reset = 1'b0;
    bus.inst_ready = 1'b1;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_valid", 32'(bus.inst_valid), 32'd1);
      check("drain_pc", bus.inst_pc, 32'(i * 4));
      check("drain_data", bus.inst_data, rom_word(32'(i * 4)));
      check("drain_count", 32'(bus.count), 32'd1);
    end
    bus.inst_ready = 1'b0;
    step();
    step();
    check("pre_areset_count", 32'(bus.count), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("areset_valid", 32'(bus.inst_valid), 32'd0);
    check("areset_count", 32'(bus.count), 32'd0);
    check("areset_addr", bus.rom_addr, 32'h0);
    step();
    reset = 1'b1;
    step();
    check("resume_pc", bus.inst_pc, 32'h0);
    check("resume_count", 32'(bus.count), 32'd1);
    check("resume_addr", bus.rom_addr, 32'h4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch stage between the program counter and decode. Drives the address of the combinational instruction ROM and captures the returned word with its PC into a small prefetch queue. Presents instructions to decode over a valid/ready handshake. Accepts branch/jump redirects from execute, which flush the queue and restart fetch.

## Interface
- `DEPTH`, 4: queue entries. Power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rom_addr` output 32: byte address to ROM; always equals `fetch_pc`.
- `rom_data` input 32: instruction word returned combinationally for `rom_addr`.
- `redirect_valid` input 1: branch/jump taken this cycle.
- `redirect_pc` input 32: redirect target byte address.
- `inst_valid` output 1: head entry available to decode.
- `inst_ready` input 1: decode accepts the head this cycle.
- `inst_data` output 32: head instruction word.
- `inst_pc` output 32: head instruction PC.
- `count` output $clog2(DEPTH)+1: current occupancy, for debug and verification.

## Operation
- **State:** `fetch_pc` register, queue of `{pc, inst}` entries, read/write pointers and `count`.
- **Pop:** occurs when `inst_valid && inst_ready`.
- **Push:** occurs when `!redirect_valid && (count < DEPTH || pop)`. The pushed entry is `{fetch_pc, rom_data}`, and `fetch_pc` advances by 4.
- **Push and pop together when full:** both occur, and `count` is unchanged.
- **Full, no pop:** no push, and `fetch_pc` holds.
- **Redirect (highest priority):**
  - At the edge, the queue is cleared (`count`=0, pointers reset).
  - `fetch_pc` loads `{redirect_pc[31:2], 2'b00}`. Bits [1:0] are dropped silently.
  - No push occurs in the redirect cycle.
  - A handshake in the same cycle still counts as a pop. Discarding wrong-path instructions is decode's responsibility.
- **`inst_valid`:** equals `count != 0`. It is not combinationally gated by `redirect_valid`.
- **Address arithmetic:** `fetch_pc` + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. No alignment check is needed beyond the redirect masking.
- **Reset values:**
  - `fetch_pc`/`rom_addr` = `RESET_PC`
  - `count` = 0
  - `inst_valid` = 0
  - `inst_data` = 0
  - `inst_pc` = 0
  - All queue storage = 0.
- **Reset mid-operation:** reset asserted at any time clears state immediately (asynchronously). Fetch resumes from `RESET_PC` at the first edge after deassertion.

## Timing
- **Latency without bypass:** 1 cycle from `rom_addr` to `inst_valid`. After reset release, `inst_valid` rises after the first `clk` edge, with `inst_pc` = `RESET_PC`.
- **Throughput:** 1 instruction/cycle while `inst_ready` is held high.
- **Redirect at edge N:**
  - `rom_addr` = target and `inst_valid` = 0 in cycle N+1.
  - The target instruction is at the head in cycle N+2 (or in cycle N+1 with bypass).
- **Combinational paths:** `rom_addr` is driven only from a register. There is no combinational path from `inst_ready` or `redirect_valid` to `rom_addr`.

## Configuration
- **`FETCH_BYPASS_EN` defined:**
  - When `count` = 0 and `!redirect_valid`, `inst_valid` = 1, `inst_data` = `rom_data` and `inst_pc` = `fetch_pc` combinationally.
  - If `inst_ready` is high, the word is consumed directly: no push, and `fetch_pc` += 4.
  - Otherwise the normal push occurs.
  - Result: zero added fetch latency, at the cost of a ROM-to-decode combinational path.
- **`FETCH_BYPASS_EN` undefined:** outputs come only from queue storage, giving the 1-cycle latency above.

## Structure
- **Package `fetch_pkg`:**
  - `fetch_entry_t` packed struct `{logic [31:0] pc; logic [31:0] inst;}`
  - `FETCH_DEPTH_DEFAULT` = 4
  - `INST_NOP` = 32'h0000_0013
- **Sub-module `fetch_fifo`:** synchronous FIFO of `fetch_entry_t` with `flush`, `push`, `pop`, `full`, `empty` and `count`. The top level holds the PC logic, redirect priority and the bypass mux.

## Test plan
1. **Fill without drain:** release reset, `inst_ready`=0 for 6 cycles. Required: `count`=4, `rom_addr`=32'h10, `inst_pc`=0, `inst_data`=32'h00110233 (ROM word 0 = `add x4,x2,x1`); `rom_addr` stays 32'h10.
2. **Continuous drain:** `inst_ready`=1 from reset. Required: `inst_pc` = 0, 4, 8, C on consecutive cycles with the matching ROM words, and no bubbles after the first valid.
3. **Redirect while full:** queue full, pulse `redirect_valid` with `redirect_pc`=32'h50. Required: next cycle `count`=0, `inst_valid`=0, `rom_addr`=32'h50; one cycle later `inst_pc`=32'h50.
4. **Misaligned target:** `redirect_pc`=32'h52. Required: fetch resumes at 32'h50.
5. **Full with simultaneous push/pop:** hold `inst_ready`=1 at `count`=4. Required: `count` stays 4 and `rom_addr` advances by 4 per cycle.
6. **Asynchronous reset mid-cycle:** assert `reset` between edges while `count`=3. Required: immediately `inst_valid`=0, `count`=0, `rom_addr`=`RESET_PC`.
